// File: rtl/my_xor_pkg.sv
// Shared constants for the parity unit: default widths and register reset values.
package my_xor_pkg;
  localparam int   DEFAULT_WIDTH = 2;
  localparam int   DEFAULT_CNT_W = 8;
  localparam logic OUT_RST       = 1'b0;
  localparam logic VALID_RST     = 1'b0;
  localparam logic ACC_RST       = 1'b0;
endpackage

// File: rtl/my_xor_reduce.sv
// Combinational WIDTH-bit reduction XOR, built as a ripple chain so WIDTH=1 is a plain wire.
module my_xor_reduce #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] vec,
  output logic             parity
);
  logic [WIDTH-1:0] chain;

  assign chain[0] = vec[0];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign chain[gi] = chain[gi-1] ^ vec[gi];
    end
  endgenerate

  assign parity = chain[WIDTH-1];
endmodule

// File: rtl/my_xor_unit.sv
// Registered parity unit with saturating odd-parity counter.
// Optional running-parity accumulator is compiled in when MY_XOR_UNIT_ACC_EN is defined.
module my_xor_unit
  import my_xor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] bus,
  output logic             out,
  output logic             out_valid,
  output logic [CNT_W-1:0] odd_cnt,
  input  logic             acc_clr,
  output logic             acc_out
);
  logic             parity;
  logic             out_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;

  my_xor_reduce #(.WIDTH(WIDTH)) u_reduce (
    .vec    (bus),
    .parity (parity)
  );

  // parity is only consumed under in_valid, so X/Z on an idle bus never reaches state
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg   <= OUT_RST;
      valid_reg <= VALID_RST;
      cnt_reg   <= '0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        out_reg <= parity;
        if (parity && (cnt_reg != {CNT_W{1'b1}}))
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign odd_cnt   = cnt_reg;

`ifdef MY_XOR_UNIT_ACC_EN
  logic acc_reg;

  // A clear coinciding with a new vector restarts the accumulator at that vector's parity
  always_ff @(posedge clk) begin
    if (rst)
      acc_reg <= ACC_RST;
    else if (acc_clr)
      acc_reg <= in_valid ? parity : ACC_RST;
    else if (in_valid)
      acc_reg <= acc_reg ^ parity;
  end

  assign acc_out = acc_reg;
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;
  assign acc_out        = ACC_RST;
`endif
endmodule

// File: tb/tb_my_xor_unit.sv
// Scoreboard bench for my_xor_unit: directed plan vectors followed by random traffic.
module tb_my_xor_unit;
  localparam int WIDTH = 2;
  localparam int CNT_W = 2;

  typedef struct {
    logic             par;
    logic [CNT_W-1:0] cnt;
    logic             acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] bus;
  logic             acc_clr;
  logic             out;
  logic             out_valid;
  logic [CNT_W-1:0] odd_cnt;
  logic             acc_out;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // reference state: what the outputs should show after the latest edge
  logic m_out = 1'b0;
  int   m_cnt = 0;
  logic m_acc = 1'b0;

  my_xor_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .bus       (bus),
    .out       (out),
    .out_valid (out_valid),
    .odd_cnt   (odd_cnt),
    .acc_clr   (acc_clr),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  function automatic logic ref_parity(input logic [WIDTH-1:0] v);
    return logic'($countones(v) % 2);
  endfunction

  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] b, input logic c);
    logic p;
    exp_t e;
    rst = r; in_valid = v; bus = b; acc_clr = c;
    p = ref_parity(b);
    @(posedge clk);
    #1;
    if (r) begin
      m_out = 1'b0; m_cnt = 0; m_acc = 1'b0;
    end else begin
`ifdef MY_XOR_UNIT_ACC_EN
      if (c) m_acc = 1'b0;
      if (v) m_acc = m_acc ^ p;
`endif
      if (v) begin
        m_out = p;
        if (p && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        e.par = m_out; e.cnt = CNT_W'(m_cnt); e.acc = m_acc;
        exp_q.push_back(e);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // monitor: pops one expectation per out_valid, otherwise outputs must hold the model state
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      n_vec++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_valid: got out_valid=1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("out", CNT_W'(out), CNT_W'(e.par));
          check("odd_cnt", odd_cnt, e.cnt);
          check("acc_out", CNT_W'(acc_out), CNT_W'(e.acc));
        end
      end else begin
        if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_err++;
          $display("FAIL missing_valid: got out_valid=%b expected 1 at %0t", out_valid, $time);
        end
        check("valid_low", CNT_W'(out_valid), '0);
        check("hold_out", CNT_W'(out), CNT_W'(m_out));
        check("hold_cnt", odd_cnt, CNT_W'(m_cnt));
        check("hold_acc", CNT_W'(acc_out), CNT_W'(m_acc));
      end
      $display("cyc t=%0t rst=%b in_valid=%b bus=%b clr=%b -> out=%b valid=%b cnt=%0d acc=%b",
               $time, rst, in_valid, bus, acc_clr, out, out_valid, odd_cnt, acc_out);
    end
  end

  initial begin
    logic [WIDTH-1:0] tt [4];
    tt[0] = 2'b11; tt[1] = 2'b00; tt[2] = 2'b10; tt[3] = 2'b01;

    rst = 1'b1; in_valid = 1'b1; bus = 2'b10; acc_clr = 1'b0;
    // reset with a live vector present: dropped
    step(1'b1, 1'b1, 2'b10, 1'b0);
    step(1'b1, 1'b1, 2'b10, 1'b0);

    foreach (tt[i]) step(1'b0, 1'b1, tt[i], 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b11, 1'b0);

    // saturation from a clean count
    step(1'b1, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b10, 1'b0);

    // accumulator sequence, including clear-with-vector and clear alone
    step(1'b1, 1'b0, 2'b00, 1'b0);
    step(1'b0, 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b0);
    step(1'b0, 1'b1, 2'b10, 1'b0);
    step(1'b0, 1'b1, 2'b01, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 2'b00, 1'b0);

    // mid-stream reset drops the vector in the reset cycle
    step(1'b0, 1'b1, 2'b01, 1'b0);
    step(1'b1, 1'b1, 2'b01, 1'b0);
    step(1'b0, 1'b0, 2'b00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0),
           WIDTH'($urandom),
           ($urandom_range(0, 9) == 0));
    end
    step(1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
